exec_step_controller: RTL
=========================

// Module: exec_step_controller
// PURPOSE
//  Run-control sequencer for the 8-bit microprocessor core. It sits between the debug/host
//  interface and the program sequencer, instruction decoder and datapath. It gates execution
//  through cpu_en, holds the core in reset after power-up, and provides run, halt and N-step
//  modes. A single PC breakpoint stops execution before the matching instruction executes.
// PARAMETERS
//  PC_WIDTH     8   width of pm_addr / bp_addr
//  CNT_WIDTH    16  width of step_count, steps_left, instr_count
//  RESET_CYCLES 2   cycles cpu_reset is held after sync_reset_n releases (>=1)
// PORTS
//  clk          in   1          system clock, all logic on rising edge
//  sync_reset_n in   1          synchronous reset, active-low
//  run_req      in   1          level/pulse: enter RUN (sampled in HALT only)
//  halt_req     in   1          level/pulse: stop after the current cycle
//  step_req     in   1          pulse: execute step_count instructions (sampled in HALT only)
//  step_count   in   CNT_WIDTH  number of instructions per step request
//  bp_en        in   1          breakpoint enable
//  bp_addr      in   PC_WIDTH   breakpoint PC
//  pm_addr      in   PC_WIDTH   current PC from the program sequencer
//  cpu_reset    out  1          drives the core's sync_reset (active-high)
//  cpu_en       out  1          clock enable for PC, ir and datapath registers
//  halted       out  1          1 in HALT state
//  bp_hit       out  1          sticky: the last stop was caused by the breakpoint
//  steps_left   out  CNT_WIDTH  instructions remaining in STEP
//  instr_count  out  CNT_WIDTH  instructions executed since reset, wraps modulo 2^CNT_WIDTH
// BEHAVIOUR
//  States: RST_HOLD, HALT, RUN, STEP. The state, counters and bp_hit are registered.
//   cpu_en, cpu_reset and halted are combinational from the state (plus the bp compare).
//  Reset: sync_reset_n=0 at an edge forces RST_HOLD from any state, including mid-RUN or
//   mid-STEP. It clears hold_cnt, steps_left, instr_count and bp_hit.
//  Output values while in reset: cpu_reset=1, cpu_en=1, halted=0, bp_hit=0.
//   cpu_en=1 here so the core's synchronous resets take effect.
//  RST_HOLD: cpu_reset=1 and cpu_en=1.
//   - hold_cnt counts the cycles with sync_reset_n=1.
//   - After RESET_CYCLES such cycles, go to HALT.
//   - instr_count does not increment in this state.
//  HALT: cpu_en=0, cpu_reset=0, halted=1. Request priority is halt_req > run_req > step_req.
//   - halt_req=1: stay in HALT.
//   - run_req=1: go to RUN and clear bp_hit.
//   - step_req=1 with step_count!=0: go to STEP, load steps_left=step_count, clear bp_hit.
//   - step_req=1 with step_count==0: ignored; stay in HALT.
//  RUN: cpu_en=1 unless a breakpoint fires.
//   - halt_req=1: the instruction in this cycle still executes (cpu_en=1); next state HALT.
//  STEP: cpu_en=1.
//   - steps_left decrements on each edge where cpu_en=1.
//   - When steps_left==1 at such an edge: go to HALT with steps_left=0.
//   - halt_req aborts: go to HALT and keep steps_left at its decremented value.
//  Breakpoint, in RUN or STEP: bp_fire = bp_en & (pm_addr==bp_addr) & ~first_cycle.
//   - When bp_fire=1: cpu_en=0 in that cycle, so the instruction at bp_addr is NOT executed.
//   - On the same edge: next state HALT, bp_hit<=1; steps_left is not decremented.
//   - first_cycle=1 in the first cycle after leaving HALT, so resuming at bp_addr executes it.
//   - A breakpoint takes priority over halt_req in the same cycle.
//  instr_count: increments by 1 on every edge with cpu_en=1 and state!=RST_HOLD; wraps at
//   all-ones to 0.
//  In RUN, run_req and step_req are ignored; in STEP, run_req and step_req are ignored.
//  No combinational path from the request inputs to cpu_en. pm_addr -> cpu_en is combinational.
// TESTING
//  1 Release sync_reset_n -> cpu_reset=1 for 2 cycles, then halted=1, cpu_en=0, instr_count=0.
//  2 HALT, step_count=3, one-cycle step_req -> cpu_en=1 for exactly 3 cycles, then halted=1,
//    instr_count=3, steps_left=0.
//  3 bp_en=1, bp_addr=8'h05, run_req with PC counting from 0 -> cpu_en=0 when pm_addr=5,
//    halted=1, bp_hit=1, instr_count=5. Then run_req -> the instruction at 5 executes,
//    PC reaches 6, bp_hit=0.
//  4 HALT, run_req=1 and halt_req=1 in the same cycle -> stays HALT, cpu_en=0.
//    step_req with step_count=0 -> stays HALT.
//  5 STEP with steps_left=10, drive sync_reset_n=0 -> next cycle cpu_reset=1, steps_left=0,
//    instr_count=0.
//  6 instr_count preset near 16'hFFFF via a run -> wraps to 16'h0000 with no stall.
//    halt_req in RUN -> exactly one more cpu_en cycle.

Source files
------------

// File: rtl/exec_step_controller.sv
// Run-control sequencer: holds the core in reset, then gates cpu_en for run, halt and N-step modes.
// A single PC breakpoint stops the core before the matching instruction executes.
module exec_step_controller #(
   parameter int PC_WIDTH     = 8,
   parameter int CNT_WIDTH    = 16,
   parameter int RESET_CYCLES = 2
) (
   input  logic                 clk,
   input  logic                 sync_reset_n,
   input  logic                 run_req,
   input  logic                 halt_req,
   input  logic                 step_req,
   input  logic [CNT_WIDTH-1:0] step_count,
   input  logic                 bp_en,
   input  logic [PC_WIDTH-1:0]  bp_addr,
   input  logic [PC_WIDTH-1:0]  pm_addr,
   output logic                 cpu_reset,
   output logic                 cpu_en,
   output logic                 halted,
   output logic                 bp_hit,
   output logic [CNT_WIDTH-1:0] steps_left,
   output logic [CNT_WIDTH-1:0] instr_count
);

   localparam int HOLD_W = (RESET_CYCLES < 2) ? 1 : $clog2(RESET_CYCLES);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_CYCLES - 1);

   typedef enum logic [1:0] {
      S_RST_HOLD = 2'd0,
      S_HALT     = 2'd1,
      S_RUN      = 2'd2,
      S_STEP     = 2'd3
   } state_t;

   state_t            state;
   state_t            state_next;
   logic [HOLD_W-1:0] hold_cnt;
   logic              first_cycle;
   logic              bp_fire;
   logic              executing;

   // first_cycle masks the compare so resuming at bp_addr executes that instruction
   assign bp_fire   = bp_en && (pm_addr == bp_addr) && !first_cycle
                      && ((state == S_RUN) || (state == S_STEP));
   assign executing = cpu_en && (state != S_RST_HOLD);

   always_ff @(posedge clk) begin
      if (!sync_reset_n) begin
         state <= S_RST_HOLD;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         S_RST_HOLD: begin
            if (hold_cnt == HOLD_LAST) state_next = S_HALT;
         end
         S_HALT: begin
            if (halt_req)                              state_next = S_HALT;
            else if (run_req)                          state_next = S_RUN;
            else if (step_req && (step_count != '0))   state_next = S_STEP;
         end
         S_RUN: begin
            if (bp_fire || halt_req) state_next = S_HALT;
         end
         S_STEP: begin
            if (bp_fire || halt_req || (steps_left == CNT_WIDTH'(1))) state_next = S_HALT;
         end
         default: state_next = S_RST_HOLD;
      endcase
   end

   always_comb begin
      cpu_reset = 1'b0;
      cpu_en    = 1'b0;
      halted    = 1'b0;
      case (state)
         S_RST_HOLD: begin
            cpu_reset = 1'b1;
            cpu_en    = 1'b1;
         end
         S_HALT:  halted = 1'b1;
         S_RUN:   cpu_en = !bp_fire;
         S_STEP:  cpu_en = !bp_fire;
         default: cpu_reset = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!sync_reset_n) begin
         hold_cnt    <= '0;
         steps_left  <= '0;
         instr_count <= '0;
         bp_hit      <= 1'b0;
         first_cycle <= 1'b0;
      end else begin
         first_cycle <= (state == S_HALT) && (state_next != S_HALT);
         if (state == S_RST_HOLD) hold_cnt <= hold_cnt + 1'b1;
         if (executing) instr_count <= instr_count + 1'b1;
         case (state)
            S_HALT: begin
               if (state_next == S_RUN) begin
                  bp_hit <= 1'b0;
               end else if (state_next == S_STEP) begin
                  bp_hit     <= 1'b0;
                  steps_left <= step_count;
               end
            end
            S_RUN: begin
               if (bp_fire) bp_hit <= 1'b1;
            end
            S_STEP: begin
               if (bp_fire) bp_hit <= 1'b1;
               else         steps_left <= steps_left - 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
